mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, default 64, address width of all ports.
REQ-002 Parameter DATA_W, default 64, data width of all ports; DATA_W/8 strobe bits.
REQ-003 Parameter STARVE_LIM, default 3, maximum consecutive data grants while a fetch waits.
REQ-004 Parameter TIMEOUT, default 64, wait-cycle limit used only under MEM_ARB_TIMEOUT_EN.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-007 i_req  in  1  fetch request, held until i_ack.
REQ-008 i_addr  in  ADDR_W  fetch address.
REQ-009 i_ack  out  1  one-cycle fetch completion pulse.
REQ-010 i_rdata  out  DATA_W  fetch read data, valid only with i_ack.
REQ-011 d_req  in  1  data request, held until d_ack.
REQ-012 d_we / d_addr / d_wdata / d_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  data write enable, address, write data, byte strobes.
REQ-013 d_ack  out  1  one-cycle data completion pulse.
REQ-014 d_rdata  out  DATA_W  data read data, valid only with d_ack.
REQ-015 m_valid / m_we / m_addr / m_wdata / m_wstrb  out  1/1/ADDR_W/DATA_W/DATA_W/8  registered memory request.
REQ-016 m_ready  in  1  memory completion, one cycle; m_rdata valid that cycle.
REQ-017 m_rdata  in  DATA_W  memory read data.
REQ-018 err  out  1  timeout error pulse, coincident with the aborted ack.

Function
REQ-019 FSM states IDLE, GNT_I, GNT_D; exactly one transaction outstanding at a time.
REQ-020 IDLE: d_req=1 and (i_req=0 or starve_cnt<STARVE_LIM) -> GNT_D; else i_req=1 -> GNT_I; else stay IDLE.
REQ-021 On the IDLE->GNT_x edge, the winner's address, we, wdata and wstrb are latched into m_* and m_valid is set; fetch drives m_we=0 and m_wstrb=0.
REQ-022 m_* stay constant while in GNT_x, independent of requester inputs.
REQ-023 GNT_x with m_ready=1: x_ack=1 the same cycle, x_rdata=m_rdata, m_valid=0 and state=IDLE from the next edge.
REQ-024 Minimum transaction is 2 cycles (grant edge, then m_ready); at least one IDLE cycle between grants.
REQ-025 i_ack and d_ack are never asserted together, and never outside their own GNT state; m_ready in IDLE is ignored.
REQ-026 starve_cnt increments on each IDLE->GNT_D edge with i_req=1, saturates at STARVE_LIM, and clears on each IDLE->GNT_I edge.
REQ-027 A request dropped before its grant is simply not served; a request dropped after its grant still completes, and its ack still pulses.
REQ-028 i_rdata and d_rdata are driven with m_rdata continuously; contents are don't-care without ack, except when forced per REQ-033.

Reset
REQ-029 rst=0 at a rising edge: state=IDLE, m_valid=0, m_we=0, m_addr/m_wdata/m_wstrb=0, starve_cnt=0, wait_cnt=0.
REQ-030 During and after reset, i_ack=0, d_ack=0 and err=0.
REQ-031 Reset mid-transaction abandons the transaction with no ack; the memory side observes m_valid=0 after that edge.

Configuration
REQ-032 Macro MEM_ARB_TIMEOUT_EN compiles in a wait_cnt that counts cycles in GNT_x without m_ready.
REQ-033 With MEM_ARB_TIMEOUT_EN: when wait_cnt reaches TIMEOUT-1 with no m_ready, x_ack=1 and err=1 for one cycle, x_rdata=0, then m_valid=0 and state=IDLE; a simultaneous m_ready takes precedence with err=0.
REQ-034 Without MEM_ARB_TIMEOUT_EN: GNT_x waits indefinitely, err is tied to 0, and no wait counter exists.

Verification
REQ-035 Only i_req=1 with i_addr=0x100, m_ready one cycle after m_valid with m_rdata=0xDEAD -> m_addr=0x100, m_we=0, one-cycle i_ack with i_rdata=0xDEAD, then m_valid=0.
REQ-036 i_req and d_req both held high continuously, STARVE_LIM=3 -> grant order D,D,D,I,D,D,D,I, each with a single ack.
REQ-037 d_req store d_addr=0x8, d_wdata=0x5, d_wstrb=0x0F; d_addr changed after the grant -> m_addr stays 0x8 and m_wstrb=0x0F until d_ack.
REQ-038 rst=0 asserted two cycles into GNT_D -> no d_ack, m_valid=0 after the edge, and a subsequent i_req is served normally.
REQ-039 With MEM_ARB_TIMEOUT_EN and TIMEOUT=4, m_ready never asserted -> d_ack=1 and err=1 on the 4th GNT_D cycle with d_rdata=0; without the macro -> still waiting after 100 cycles.

Source files
------------

// File: rtl/mem_arb_if.sv
// Bundle of the fetch, data and memory-side signals of the mem_arb arbiter.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface mem_arb_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_ack;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_ack;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_valid;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_ready;
    logic [DATA_W-1:0]     m_rdata;

    logic                  err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_valid, m_we, m_addr, m_wdata, m_wstrb, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_valid, m_we, m_addr, m_wdata, m_wstrb, err
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port (fetch/data) memory arbiter with one outstanding transaction and fetch anti-starvation.
// Optional wait-cycle timeout is compiled in with the macro MEM_ARB_TIMEOUT_EN.
module mem_arb #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_LIM = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SW     = $clog2(STARVE_LIM + 2);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t              state_q, state_d;
    logic                m_valid_q, m_valid_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
    logic [SW-1:0]       starve_cnt_q, starve_cnt_d;

    logic i_ack_c, d_ack_c, err_c, zero_rdata, timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        m_valid_d    = m_valid_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        starve_cnt_d = starve_cnt_q;
        i_ack_c      = 1'b0;
        d_ack_c      = 1'b0;
        err_c        = 1'b0;
        zero_rdata   = 1'b0;
        timeout      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Data wins unless the fetch has already been passed over STARVE_LIM times.
                if (bus.d_req && (!bus.i_req || starve_cnt_q < LIM)) begin
                    state_d   = GNT_D;
                    m_valid_d = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_wstrb_d = bus.d_wstrb;
                    if (bus.i_req && starve_cnt_q < LIM)
                        starve_cnt_d = starve_cnt_q + 1'b1;
                end else if (bus.i_req) begin
                    state_d      = GNT_I;
                    m_valid_d    = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = bus.i_addr;
                    m_wdata_d    = '0;
                    m_wstrb_d    = '0;
                    starve_cnt_d = '0;
                end
            end
            GNT_I, GNT_D: begin
`ifdef MEM_ARB_TIMEOUT_EN
                timeout = !bus.m_ready && (wait_cnt_q == TMAX);
`endif
                if (bus.m_ready || timeout) begin
                    state_d    = IDLE;
                    m_valid_d  = 1'b0;
                    i_ack_c    = (state_q == GNT_I);
                    d_ack_c    = (state_q == GNT_D);
                    err_c      = timeout;
                    zero_rdata = timeout;
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // Completion pulses are suppressed in a reset cycle: the transaction is abandoned.
        if (!rst) begin
            i_ack_c = 1'b0;
            d_ack_c = 1'b0;
            err_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            m_valid_q    <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            starve_cnt_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            m_valid_q    <= m_valid_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            starve_cnt_q <= starve_cnt_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;
    assign bus.i_ack   = i_ack_c;
    assign bus.d_ack   = d_ack_c;
    assign bus.err     = err_c;
    assign bus.i_rdata = zero_rdata ? '0 : bus.m_rdata;
    assign bus.d_rdata = zero_rdata ? '0 : bus.m_rdata;
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized traffic against a
// transaction-level model (who owns the memory, what was latched at grant, how often fetch lost).
module tb_mem_arb;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int STARVE_LIM = 3;
    localparam int TIMEOUT    = 4;

    logic clk;
    logic rst;
    int   nchecks = 0;
    int   nerrors = 0;

    mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner 0 = memory free, 1 = fetch holds it, 2 = data holds it.
    int          owner = 0;
    int          fetch_losses = 0;
    int          waited = 0;
    bit          fields_known = 1'b1;
    logic        x_we = 1'b0;
    logic [63:0] x_addr = '0;
    logic [63:0] x_wdata = '0;
    logic [7:0]  x_wstrb = '0;
    bit          to_now, done_now, e_i_ack, e_d_ack;
    bit          last_i_ack = 1'b0;
    bit          last_d_ack = 1'b0;
    byte         dut_gnt[$];
    byte         mdl_gnt[$];

    always @(negedge clk) begin
        to_now = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_now = (owner != 0) && !bus.m_ready && (waited == TIMEOUT - 1);
`endif
        done_now = rst && (owner != 0) && (bus.m_ready || to_now);
        e_i_ack  = done_now && (owner == 1);
        e_d_ack  = done_now && (owner == 2);

        chk("i_ack", bus.i_ack, e_i_ack);
        chk("d_ack", bus.d_ack, e_d_ack);
        chk("err", bus.err, done_now && to_now);
        chk("m_valid", bus.m_valid, owner != 0);
        if (fields_known) begin
            chk("m_we", bus.m_we, x_we);
            chk("m_addr", bus.m_addr, x_addr);
            chk("m_wdata", bus.m_wdata, x_wdata);
            chk("m_wstrb", bus.m_wstrb, x_wstrb);
        end
        if (e_i_ack) chk("i_rdata", bus.i_rdata, to_now ? 64'h0 : bus.m_rdata);
        if (e_d_ack) chk("d_rdata", bus.d_rdata, to_now ? 64'h0 : bus.m_rdata);

        if (bus.i_ack) dut_gnt.push_back("I");
        if (bus.d_ack) dut_gnt.push_back("D");
        if (e_i_ack)   mdl_gnt.push_back("I");
        if (e_d_ack)   mdl_gnt.push_back("D");
        last_i_ack = bus.i_ack;
        last_d_ack = bus.d_ack;

        // Advance the model to what must hold after the coming rising edge.
        if (!rst) begin
            owner = 0; fetch_losses = 0; waited = 0; fields_known = 1'b1;
            x_we = 1'b0; x_addr = '0; x_wdata = '0; x_wstrb = '0;
        end else if (owner == 0) begin
            if (bus.d_req && (!bus.i_req || fetch_losses < STARVE_LIM)) begin
                owner = 2; fields_known = 1'b1;
                x_we = bus.d_we; x_addr = bus.d_addr; x_wdata = bus.d_wdata; x_wstrb = bus.d_wstrb;
                if (bus.i_req) fetch_losses = fetch_losses + 1;
            end else if (bus.i_req) begin
                owner = 1; fields_known = 1'b1; fetch_losses = 0;
                x_we = 1'b0; x_addr = bus.i_addr; x_wdata = '0; x_wstrb = '0;
            end
        end else if (done_now) begin
            owner = 0; waited = 0; fields_known = 1'b0;
        end else begin
            waited = waited + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_order;
        rst = 1'b0;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.m_ready = 0; bus.m_rdata = '0;
        step();
        look();
        chk("reset_m_valid", bus.m_valid, 1'b0);
        chk("reset_m_addr", bus.m_addr, 64'h0);
        chk("reset_ack", {bus.i_ack, bus.d_ack, bus.err}, 3'b000);
        step();
        rst = 1'b1;

        // Single fetch served.
        bus.i_req = 1; bus.i_addr = 64'h100;
        step();
        bus.m_ready = 1; bus.m_rdata = 64'hDEAD;
        look();
        chk("fetch_m_addr", bus.m_addr, 64'h100);
        chk("fetch_m_we", bus.m_we, 1'b0);
        chk("fetch_i_ack", bus.i_ack, 1'b1);
        chk("fetch_i_rdata", bus.i_rdata, 64'hDEAD);
        step();
        bus.m_ready = 0; bus.i_req = 0;
        look();
        chk("fetch_done_m_valid", bus.m_valid, 1'b0);
        chk("fetch_done_i_ack", bus.i_ack, 1'b0);
        step();

        // Both requesters held high: data wins STARVE_LIM times, then fetch.
        do_reset();
        dut_gnt.delete(); mdl_gnt.delete();
        bus.i_req = 1; bus.i_addr = 64'h200;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h300;
        for (int c = 0; c < 100 && dut_gnt.size() < 8; c++) begin
            step();
            bus.m_ready = bus.m_valid;
        end
        bus.i_req = 0; bus.d_req = 0; bus.m_ready = 0;
        exp_order = "DDDIDDDI";
        chk("starve_grant_count", dut_gnt.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < dut_gnt.size()) chk("starve_order_dut", dut_gnt[k], exp_order[k]);
            if (k < mdl_gnt.size()) chk("starve_order_model", mdl_gnt[k], exp_order[k]);
        end
        step();

        // Store keeps its latched fields while the requester changes its inputs.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h8; bus.d_wdata = 64'h5; bus.d_wstrb = 8'h0F;
        step();
        bus.d_addr = 64'h40; bus.d_wdata = 64'h77; bus.d_wstrb = 8'hFF; bus.d_we = 0;
        look();
        chk("store_m_addr", bus.m_addr, 64'h8);
        chk("store_m_wstrb", bus.m_wstrb, 8'h0F);
        chk("store_m_we", bus.m_we, 1'b1);
        step();
        look();
        chk("store_hold_m_addr", bus.m_addr, 64'h8);
        chk("store_hold_m_wdata", bus.m_wdata, 64'h5);
        step();
        bus.m_ready = 1; bus.m_rdata = 64'h99;
        look();
        chk("store_d_ack", bus.d_ack, 1'b1);
        chk("store_ack_m_wstrb", bus.m_wstrb, 8'h0F);
        step();
        bus.m_ready = 0; bus.d_req = 0;
        step();

        // Reset two cycles into a data grant abandons it.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h50;
        step();
        step();
        rst = 1'b0; bus.m_ready = 1;
        look();
        chk("rst_mid_d_ack", bus.d_ack, 1'b0);
        step();
        rst = 1'b1; bus.m_ready = 0; bus.d_req = 0;
        look();
        chk("rst_mid_m_valid", bus.m_valid, 1'b0);
        chk("rst_mid_d_ack_after", bus.d_ack, 1'b0);
        step();
        bus.i_req = 1; bus.i_addr = 64'h200;
        step();
        bus.m_ready = 1; bus.m_rdata = 64'h1234;
        look();
        chk("post_rst_i_ack", bus.i_ack, 1'b1);
        chk("post_rst_i_rdata", bus.i_rdata, 64'h1234);
        chk("post_rst_m_addr", bus.m_addr, 64'h200);
        step();
        bus.m_ready = 0; bus.i_req = 0;
        step();

        // Memory never answers.
        bus.m_rdata = 64'hBEEF;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h30;
        step();
        for (int k = 1; k <= 100; k++) begin
            look();
`ifdef MEM_ARB_TIMEOUT_EN
            if (k < TIMEOUT) begin
                chk("timeout_early_d_ack", bus.d_ack, 1'b0);
                chk("timeout_early_err", bus.err, 1'b0);
            end else begin
                chk("timeout_d_ack", bus.d_ack, 1'b1);
                chk("timeout_err", bus.err, 1'b1);
                chk("timeout_d_rdata", bus.d_rdata, 64'h0);
                break;
            end
`else
            chk("wait_d_ack", bus.d_ack, 1'b0);
            if (k == 100) chk("wait_m_valid", bus.m_valid, 1'b1);
`endif
            step();
        end
        bus.d_req = 0;
        step();
        do_reset();

        // Randomized traffic with protocol-following requesters and an erratic memory.
        for (int c = 0; c < 2500; c++) begin
            step();
            rst = ($urandom_range(0, 199) != 0);
            if (bus.i_req && last_i_ack) bus.i_req = 0;
            if (bus.i_req && $urandom_range(0, 29) == 0) bus.i_req = 0;
            else if (!bus.i_req && $urandom_range(0, 2) == 0) bus.i_req = 1;
            if ($urandom_range(0, 3) == 0) bus.i_addr = {$urandom, $urandom};
            if (bus.d_req && last_d_ack) bus.d_req = 0;
            if (bus.d_req && $urandom_range(0, 29) == 0) bus.d_req = 0;
            else if (!bus.d_req && $urandom_range(0, 2) == 0) bus.d_req = 1;
            if ($urandom_range(0, 3) == 0) begin
                bus.d_we    = $urandom_range(0, 1);
                bus.d_addr  = {$urandom, $urandom};
                bus.d_wdata = {$urandom, $urandom};
                bus.d_wstrb = 8'($urandom);
            end
            bus.m_ready = ($urandom_range(0, 2) == 0);
            bus.m_rdata = {$urandom, $urandom};
        end
        rst = 1'b1;
        bus.i_req = 0; bus.d_req = 0; bus.m_ready = 0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
